// File: rtl/bus_pkg.sv
// Shared types and constants for the two-port bus arbiter.
package bus_pkg;

  localparam int unsigned BUS_W = 32;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData
  } bus_state_t;

  typedef logic port_idx_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/response signals of the two client ports (0 = fetch, 1 = load/store).
interface bus_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_ack;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_ack;
  logic [DATA_W-1:0] p1_rdata;

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p0_ack, p0_rdata, p1_ack, p1_rdata
  );

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p0_ack, p0_rdata, p1_ack, p1_rdata
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the last-granted register lives in the caller.
module rr_arbiter2
  import bus_pkg::*;
(
  input  logic [1:0] req,
  input  port_idx_t  last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Serialises single-word requests from two ports onto the memory controller's
// address/data tri-state bus: address phase (load), then one rd or wr phase.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  bus_arbiter_if.slave      port_if,
  output logic              mem_load,
  output logic              mem_rd,
  output logic              mem_wr,
  inout  wire  [DATA_W-1:0] bus
);

  bus_state_t        state_q;
  port_idx_t         last_q;
  port_idx_t         gnt_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        ack_q;
  logic [DATA_W-1:0] rdata_q [2];
  logic              bus_oe;
  logic [DATA_W-1:0] bus_out;

  logic [1:0]        req_eff;
  logic [1:0]        gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // A port is never re-granted in its own ack cycle: its req is still the old one.
  assign req_eff = {port_if.p1_req, port_if.p0_req} & ~ack_q;

  rr_arbiter2 u_rr (
    .req  (req_eff),
    .last (last_q),
    .gnt  (gnt)
  );

  always_comb begin
    sel_we    = port_if.p0_we;
    sel_addr  = port_if.p0_addr;
    sel_wdata = port_if.p0_wdata;
    if (gnt[1]) begin
      sel_we    = port_if.p1_we;
      sel_addr  = port_if.p1_addr;
      sel_wdata = port_if.p1_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      last_q     <= 1'b1;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      ack_q      <= 2'b00;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
      mem_load   <= 1'b0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      bus_oe     <= 1'b0;
      bus_out    <= '0;
    end else begin
      ack_q    <= 2'b00;
      mem_load <= 1'b0;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      bus_oe   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|req_eff) begin
            gnt_q    <= gnt[1];
            last_q   <= gnt[1];
            we_q     <= sel_we;
            wdata_q  <= sel_wdata;
            bus_out  <= DATA_W'(sel_addr);
            bus_oe   <= 1'b1;
            mem_load <= 1'b1;
            state_q  <= StAddr;
          end
        end
        StAddr: begin
          state_q <= StData;
          if (we_q) begin
            mem_wr  <= 1'b1;
            bus_oe  <= 1'b1;
            bus_out <= wdata_q;
          end else begin
            // Bus released in the same cycle rd rises so the controller can drive it.
            mem_rd <= 1'b1;
          end
        end
        StData: begin
          state_q      <= StIdle;
          ack_q[gnt_q] <= 1'b1;
          if (!we_q) begin
            rdata_q[gnt_q] <= bus;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus = bus_oe ? bus_out : 'z;

  assign port_if.p0_ack   = ack_q[0];
  assign port_if.p1_ack   = ack_q[1];
  assign port_if.p0_rdata = rdata_q[0];
  assign port_if.p1_rdata = rdata_q[1];

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a small behavioural memory controller
// (ROM below 0x40, RAM 0x40-0x7f, LED register at 0x80).
module tb_bus_arbiter;
  import bus_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) port_if ();

  logic        mem_load;
  logic        mem_rd;
  logic        mem_wr;
  wire  [31:0] bus;

  bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .port_if  (port_if),
    .mem_load (mem_load),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .bus      (bus)
  );

  // Memory controller model
  logic [31:0] mem [64];
  logic [31:0] mem_addr_q = '0;
  logic [7:0]  leds = '0;
  logic [31:0] mem_dout;

  assign mem_dout = mem[mem_addr_q[7:2]];
  assign bus      = mem_rd ? mem_dout : 'z;

  always @(posedge clk) begin
    if (mem_load) mem_addr_q <= bus;
    if (mem_wr) begin
      if (mem_addr_q == 32'h80) leds <= bus[7:0];
      else if (mem_addr_q >= 32'h40 && mem_addr_q < 32'h80) mem[mem_addr_q[7:2]] <= bus;
    end
  end

  // Cycle counter, load-phase log and whole-run protocol monitor
  int          cyc = 0;
  int          load_cyc [$];
  logic [31:0] load_addr [$];
  int          p0_acks = 0;
  int          p1_acks = 0;
  int          viol = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_load) begin
        load_cyc.push_back(cyc);
        load_addr.push_back(bus);
      end
      if (port_if.p0_ack) p0_acks++;
      if (port_if.p1_ack) p1_acks++;
      if (mem_rd && dut.bus_oe) viol++;
      if (int'(mem_load) + int'(mem_rd) + int'(mem_wr) > 1) viol++;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(input int port, input string tag);
    int n = 0;
    logic seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      seen = (port == 0) ? port_if.p0_ack : port_if.p1_ack;
    end
    check({tag, "_ack_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    int          n;
    int          a1;
    logic [31:0] exp_addr [4];
    exp_addr[0] = 32'h04;
    exp_addr[1] = 32'h44;
    exp_addr[2] = 32'h04;
    exp_addr[3] = 32'h44;

    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[1]  = 32'h0000_0093;
    mem[18] = 32'h1234_5678;

    rst = 1'b1;
    port_if.p0_req = 1'b0; port_if.p0_we = 1'b0; port_if.p0_addr = '0; port_if.p0_wdata = '0;
    port_if.p1_req = 1'b0; port_if.p1_we = 1'b0; port_if.p1_addr = '0; port_if.p1_wdata = '0;

    repeat (2) @(negedge clk);
    check("rst_p0_ack", 32'(port_if.p0_ack), 32'd0);
    check("rst_p1_ack", 32'(port_if.p1_ack), 32'd0);
    check("rst_p0_rdata", port_if.p0_rdata, 32'd0);
    check("rst_p1_rdata", port_if.p1_rdata, 32'd0);
    check("rst_strobes", 32'({mem_load, mem_rd, mem_wr}), 32'd0);
    check("rst_bus_oe", 32'(dut.bus_oe), 32'd0);

    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Port 0 read of ROM word 1, cycle-exact
    port_if.p0_req = 1'b1; port_if.p0_we = 1'b0; port_if.p0_addr = 32'h4;
    @(negedge clk);
    check("t1_no_comb_load", 32'(mem_load), 32'd0);
    @(negedge clk);
    check("t1_load", 32'(mem_load), 32'd1);
    check("t1_bus_addr", bus, 32'h4);
    @(negedge clk);
    check("t1_rd", 32'(mem_rd), 32'd1);
    check("t1_rd_released", 32'(dut.bus_oe), 32'd0);
    @(negedge clk);
    check("t1_ack", 32'(port_if.p0_ack), 32'd1);
    check("t1_rdata", port_if.p0_rdata, 32'h0000_0093);
    @(posedge clk); #1 port_if.p0_req = 1'b0;
    @(negedge clk);
    check("t1_ack_width", 32'(port_if.p0_ack), 32'd0);
    check("t1_rdata_hold", port_if.p0_rdata, 32'h0000_0093);

    // Port 1 write then read of RAM 0x44, req held across both
    load_cyc.delete(); load_addr.delete();
    @(posedge clk); #1;
    port_if.p1_req = 1'b1; port_if.p1_we = 1'b1;
    port_if.p1_addr = 32'h44; port_if.p1_wdata = 32'hDEAD_BEEF;
    wait_ack(1, "t2_wr");
    check("t2_wr_rdata_kept", port_if.p1_rdata, 32'd0);
    @(posedge clk); #1 port_if.p1_we = 1'b0;
    wait_ack(1, "t2_rd");
    check("t2_rdata", port_if.p1_rdata, 32'hDEAD_BEEF);
    check("t2_nloads", 32'(load_cyc.size()), 32'd2);
    n = (load_cyc.size() >= 2) ? load_cyc[1] - load_cyc[0] : -1;
    check("t2_spacing", 32'(n), 32'd4);
    @(posedge clk); #1 port_if.p1_req = 1'b0;

    // Port 1 write to the LED register
    @(posedge clk); #1;
    port_if.p1_req = 1'b1; port_if.p1_we = 1'b1;
    port_if.p1_addr = 32'h80; port_if.p1_wdata = 32'h0000_00A5;
    wait_ack(1, "t3");
    check("t3_leds", 32'(leds), 32'hA5);
    check("t3_rdata_kept", port_if.p1_rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1 port_if.p1_req = 1'b0;

    // Reset, then sustained contention from both ports
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("t4_rst_p1_rdata", port_if.p1_rdata, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    load_cyc.delete(); load_addr.delete();
    port_if.p0_req = 1'b1; port_if.p0_we = 1'b0; port_if.p0_addr = 32'h04;
    port_if.p1_req = 1'b1; port_if.p1_we = 1'b0; port_if.p1_addr = 32'h44;
    n = 0;
    while (load_cyc.size() < 4 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("t4_nloads", 32'(load_cyc.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i < load_cyc.size()) begin
        check($sformatf("t4_grant%0d_addr", i), load_addr[i], exp_addr[i]);
        if (i > 0) check($sformatf("t4_gap%0d", i), 32'(load_cyc[i] - load_cyc[i-1]), 32'd3);
      end
    end
    @(posedge clk); #1 port_if.p0_req = 1'b0; port_if.p1_req = 1'b0;
    repeat (5) @(negedge clk);
    check("t4_p0_rdata", port_if.p0_rdata, 32'h0000_0093);
    check("t4_p1_rdata", port_if.p1_rdata, 32'hDEAD_BEEF);

    // Reset asserted during the data phase of a write to 0x48
    @(posedge clk); #1;
    port_if.p1_req = 1'b1; port_if.p1_we = 1'b1;
    port_if.p1_addr = 32'h48; port_if.p1_wdata = 32'hCAFE_F00D;
    n = 0;
    while (!mem_wr && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t5_in_data", 32'(mem_wr), 32'd1);
    a1 = p1_acks;
    #1 rst = 1'b1;
    #1;
    check("t5_strobes", 32'({mem_load, mem_rd, mem_wr}), 32'd0);
    check("t5_bus_oe", 32'(dut.bus_oe), 32'd0);
    check("t5_state", 32'(dut.state_q), 32'(StIdle));
    check("t5_ack", 32'(port_if.p1_ack), 32'd0);
    port_if.p1_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_no_ack", 32'(p1_acks - a1), 32'd0);
    check("t5_ram_kept", mem[18], 32'h1234_5678);

    check("no_contention", 32'(viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-port arbiter and sequencer in front of `memory_controller`: port 0 (instruction fetch) and port 1 (load/store) each issue single-word read or write requests. The arbiter serialises them onto the controller's shared tri-state bus using the controller's address/data protocol. The protocol is an address phase with `load` high and `bus` = address, then one data phase with `rd` or `wr` high. Round-robin fairness between the ports; one transaction in flight at a time.

## Interface
- `ADDR_W`, 32, request address width (equals bus width)
- `DATA_W`, 32, data width (equals bus width)

- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `p0_req`, `p1_req`  in  1  request; held until and including the ack cycle
- `p0_we`, `p1_we`  in  1  1 = write, 0 = read; stable while req high
- `p0_addr`, `p1_addr`  in  ADDR_W  byte address, passed unmodified
- `p0_wdata`, `p1_wdata`  in  DATA_W  write data, stable while req high
- `p0_ack`, `p1_ack`  out  1  one-cycle completion pulse
- `p0_rdata`, `p1_rdata`  out  DATA_W  read data, valid from ack cycle until next read completion on that port
- `mem_load`  out  1  to controller `load`
- `mem_rd`  out  1  to controller `rd`
- `mem_wr`  out  1  to controller `wr`
- `bus`  inout  DATA_W  shared bus; driven only when the arbiter owns it, else `'z`

## Operation
- States: IDLE, ADDR, DATA.
- IDLE:
  - Form an effective request vector: req masked by the port currently acking.
  - If any effective request exists, latch grant, we, addr and wdata of the chosen port, then go to ADDR.
  - With no effective request, stay in IDLE.
- ADDR: `mem_load`=1, `bus` driven with latched addr; go to DATA.
- DATA, read: `mem_rd`=1, `bus` released. At the edge leaving DATA, capture `bus` into the granted port's rdata and set its ack.
- DATA, write: `mem_wr`=1, `bus` driven with latched wdata. At the edge leaving DATA, set the granted port's ack.
- DATA always returns to IDLE.
- Arbitration is round-robin. `last` holds the most recently granted port.
  - Both ports effective: grant `!last`.
  - One port effective: grant that port.
  - `last` updates on every grant.
- Stale-request mask: a port's req is ignored in its own ack cycle, so it is never re-granted. The other port may be granted in that same cycle.
- Address decode belongs to the controller. Unmapped reads complete normally with undefined rdata. Writes to ROM complete normally with no effect. No timeout.
- `mem_load`, `mem_rd` and `mem_wr` are mutually exclusive.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, `last`=1 (port 0 wins first contention).
  - `mem_load`/`mem_rd`/`mem_wr`=0, `bus` released.
  - Both ack=0, both rdata=0.
  - An in-flight transaction is dropped with no ack.
- `mem_*` strobes and bus enable decode from state only, with no combinational path from req.
- Latency: req sampled high in IDLE at edge N gives ADDR in cycle N+1, DATA in N+2, ack in N+3.
- Throughput: 3 cycles per transaction when alternating ports; a same-port back-to-back request is 4 cycles (masked in its ack cycle).
- Ack width is exactly 1 cycle. rdata updates only on a read ack of that port. Write acks leave rdata unchanged.
- Bus turnaround: the arbiter releases `bus` in the same cycle `mem_rd` rises. ADDR after a read DATA has one IDLE cycle between them, so no driver overlap.

## Structure
- Package `bus_pkg`:
  - `bus_state_t` enum (IDLE, ADDR, DATA).
  - `BUS_W`=32.
  - Port index type.
- Sub-module `rr_arbiter2`:
  - Inputs: effective req[1:0], `last`.
  - Outputs: one-hot grant.
  - Purely combinational; `last` register stays in `bus_arbiter`.
- Tri-state via a single `bus_oe` and `bus_out`: `bus = bus_oe ? bus_out : 'z`.

## Test plan
- Port 0 read of 0x0000_0004 with ROM word 1 = 0x0000_0093:
  - `mem_load`=1 with bus=0x4 in cycle N+1.
  - `mem_rd`=1 in N+2.
  - `p0_ack`=1 with `p0_rdata`=0x0000_0093 in N+3.
- Port 1 write 0xDEAD_BEEF to 0x0000_0044, then port 1 read of 0x44:
  - rdata=0xDEAD_BEEF.
  - Second grant starts 4 cycles after the first (same-port mask).
- Port 1 write 0x0000_00A5 to 0x0000_0080 → `leds`=0xA5 one cycle after DATA. `p1_rdata` unchanged.
- Both ports request in the same cycle from reset:
  - Port 0 granted first, port 1 granted in port 0's ack cycle.
  - Sustained contention alternates 0,1,0,1 with 3-cycle spacing.
- `rst` asserted during DATA of a write to 0x48:
  - Immediate IDLE, strobes 0, bus `'z`, no ack.
  - RAM word at 0x48 unchanged if `rst` arrives before the edge.
- Bus contention check for the whole run: never `mem_rd` with arbiter `bus_oe`=1; never two strobes high at once.
